// File: rtl/counter_down_reload_pkg.sv
// Shared de_coder timer definitions: run-control FSM state encoding.
package counter_down_reload_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/counter_down_reload.sv
// Loadable down-counting interval timer with borrow/done flags and one-shot or
// auto-reload run control.
module counter_down_reload #(
    parameter int unsigned       Width = 10,
    parameter logic [Width-1:0]  St    = '1,
    parameter logic [Width-1:0]  End   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [Width-1:0] din,
    input  logic             start,
    input  logic             stop,
    input  logic             auto,
    output logic [Width-1:0] q,
    output logic             bo,
    output logic             done,
    output logic             busy
);
    import counter_down_reload_pkg::*;

    localparam logic [Width-1:0] ONE = Width'(1);

    logic [Width-1:0] q_q, q_d;
    logic [1:0]       state_q, state_d;
    logic             done_q, busy_q;

    // Terminal event only counts when neither stop nor load pre-empts it, so
    // done is always exactly the registered borrow.
    assign bo = (state_q == ST_RUN) && en && (q_q == End) && !load && !stop;

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (load) begin
            q_d = din;
        end else if (start && state_q != ST_RUN) begin
            state_d = ST_RUN;
            if (state_q == ST_DONE) q_d = St;
        end else if (state_q == ST_RUN && en) begin
            if (q_q == End) begin
                if (auto) q_d = St;
                else      state_d = ST_DONE;
            end else begin
                q_d = q_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q     <= St;
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            done_q  <= bo;
            busy_q  <= (state_d == ST_RUN);
        end
    end

    assign q    = q_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_counter_down_reload.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops
// and compares. Two instances: St=9/End=0 and the degenerate St=End=0.
module tb_counter_down_reload;

    typedef struct { int q; bit running; bit finished; bit prev_term; } mdl_t;
    typedef struct { int q; bit bo; bit done; bit busy; } exp_t;
    typedef struct { bit en; bit load; bit start; bit stop; bit au; bit rst; int din; } stim_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, auto_s = 1'b0;
    logic [3:0] din = 4'h0;
    logic [3:0] q1, q2;
    logic       bo1, done1, busy1, bo2, done2, busy2;

    int checks = 0;
    int failures = 0;

    exp_t q_exp1[$];
    exp_t q_exp2[$];
    mdl_t m1, m2;

    always #5 clk = ~clk;

    counter_down_reload #(.Width(4), .St(4'h9), .End(4'h0)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .din(din),
        .start(start), .stop(stop), .auto(auto_s),
        .q(q1), .bo(bo1), .done(done1), .busy(busy1));

    counter_down_reload #(.Width(4), .St(4'h0), .End(4'h0)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .din(din),
        .start(start), .stop(stop), .auto(auto_s),
        .q(q2), .bo(bo2), .done(done2), .busy(busy2));

    // Behavioural reference: running/finished flags and a plain integer count.
    task automatic model_step(input int st, input int endv, input stim_t s,
                              inout mdl_t m, output exp_t e);
        bit term;
        if (s.rst) begin
            m = '{q: st, running: 0, finished: 0, prev_term: 0};
            e = '{q: st, bo: 0, done: 0, busy: 0};
            return;
        end
        term   = m.running && s.en && (m.q == endv) && !s.load && !s.stop;
        e.q    = m.q;
        e.bo   = term;
        e.done = m.prev_term;
        e.busy = m.running;
        if (s.stop) begin
            m.running = 0; m.finished = 0;
        end else if (s.load) begin
            m.q = s.din;
        end else if (s.start && !m.running) begin
            if (m.finished) m.q = st;
            m.running = 1; m.finished = 0;
        end else if (m.running && s.en) begin
            if (term) begin
                if (s.au) m.q = st;
                else begin m.running = 0; m.finished = 1; end
            end else begin
                m.q = (m.q + 15) % 16;
            end
        end
        m.prev_term = term;
    endtask

    task automatic cyc(input bit st_, input bit sp, input bit ld, input bit en_,
                       input bit au, input int d, input bit rs = 1'b0);
        stim_t s;
        exp_t  e1, e2;
        @(posedge clk); #1;
        reset_n = !rs; start = st_; stop = sp; load = ld; en = en_;
        auto_s = au; din = d[3:0];
        s = '{en: en_, load: ld, start: st_, stop: sp, au: au, rst: rs, din: d};
        model_step(9, 0, s, m1, e1);
        model_step(0, 0, s, m2, e2);
        q_exp1.push_back(e1);
        q_exp2.push_back(e2);
    endtask

    task automatic chk(input string nm, input exp_t e, input logic [3:0] aq,
                       input logic ab, input logic ad, input logic au);
        logic [3:0] eq;
        eq = e.q[3:0];
        checks++;
        if (aq !== eq || ab !== e.bo || ad !== e.done || au !== e.busy) begin
            failures++;
            $display("FAIL %s t=%0t actual q=%0d bo=%b done=%b busy=%b required q=%0d bo=%b done=%b busy=%b",
                     nm, $time, aq, ab, ad, au, eq, e.bo, e.done, e.busy);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp1.size() > 0) begin
                e = q_exp1.pop_front();
                chk("dut1", e, q1, bo1, done1, busy1);
            end
            if (q_exp2.size() > 0) begin
                e = q_exp2.pop_front();
                chk("dut2", e, q2, bo2, done2, busy2);
            end
        end
    end

    initial begin
        bit au_r;
        m1 = '{q: 9, running: 0, finished: 0, prev_term: 0};
        m2 = '{q: 0, running: 0, finished: 0, prev_term: 0};
        // reset state
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        // one-shot run 9..0, done, then hold in DONE
        cyc(1, 0, 0, 1, 0, 0);
        repeat (13) cyc(0, 0, 0, 1, 0, 0);
        // auto-reload from DONE: start reloads St
        cyc(1, 0, 0, 1, 1, 0);
        repeat (25) cyc(0, 0, 0, 1, 1, 0);
        // load collides with terminal count, then start+stop together
        for (int k = 0; k < 16 && m1.q != 0; k++) cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 5);
        cyc(1, 1, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        // load in IDLE then start with en toggling
        cyc(0, 0, 1, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, (i % 2) == 0, 0, 0);
        // async reset mid-count at q=4
        cyc(1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 16 && m1.q != 4; k++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        // load below End in RUN wraps (here End=0 so values above start wrap behaviour via reload)
        cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 2);
        repeat (5) cyc(0, 0, 0, 1, 1, 0);
        // randomized traffic
        au_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) au_r = $urandom_range(0, 1) == 1;
            cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 75,
                au_r, $urandom_range(0, 15), $urandom_range(0, 199) == 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checks++;
        if (q_exp1.size() != 0 || q_exp2.size() != 0) begin
            failures++;
            $display("FAIL drain actual pending=%0d/%0d required 0/0", q_exp1.size(), q_exp2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
